// File: rtl/arbiter_puf_engine.sv
// Sequencer for an external arbiter-PUF delay chain. Each response bit comes from its own
// LFSR-generated challenge, evaluated VOTES times and majority-voted.
module arbiter_puf_engine #(
  parameter int                  C_LENGTH      = 16,
  parameter int                  RESP_BITS     = 8,
  parameter int                  VOTES         = 5,
  parameter int                  LOW_CYCLES    = 2,
  parameter int                  SETTLE_CYCLES = 4,
  parameter logic [C_LENGTH-1:0] TAPS          = 16'hB400
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [C_LENGTH-1:0]            seed,
  output logic                           busy,
  output logic                           puf_launch,
  output logic [C_LENGTH-1:0]            puf_challenge,
  input  logic                           puf_result,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [RESP_BITS-1:0]           resp_data,
  output logic [$clog2(RESP_BITS+1)-1:0] resp_unstable
);

  localparam int ONES_W = $clog2(VOTES + 1);
  localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int PH_MAX = (LOW_CYCLES > SETTLE_CYCLES) ? LOW_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int UNST_W = $clog2(RESP_BITS + 1);

  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("VOTES must be odd and at least 1");
  end
  if (LOW_CYCLES < 1) begin : g_bad_low
    $error("LOW_CYCLES must be at least 1");
  end
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOW, S_HIGH, S_VOTE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [C_LENGTH-1:0]   seed_q, seed_d;
  logic [C_LENGTH-1:0]   chal_q, chal_d;
  logic                  sync1_q, sync2_q;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [ONES_W-1:0]     vote_q, vote_d;
  logic [ONES_W-1:0]     ones_q, ones_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [RESP_BITS-1:0]  data_q, data_d;
  logic [UNST_W-1:0]     unst_q, unst_d;

  function automatic logic [C_LENGTH-1:0] lfsr_step(input logic [C_LENGTH-1:0] c);
    lfsr_step = c[0] ? ((c >> 1) ^ TAPS) : (c >> 1);
  endfunction

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path can infer a latch.
    state_d = state_q;
    seed_d  = seed_q;
    chal_d  = chal_q;
    phase_d = phase_q;
    vote_d  = vote_q;
    ones_d  = ones_q;
    bit_d   = bit_q;
    data_d  = data_q;
    unst_d  = unst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d  = (seed == '0) ? C_LENGTH'(1) : seed;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        chal_d  = seed_q;
        phase_d = '0;
        vote_d  = '0;
        ones_d  = '0;
        bit_d   = '0;
        data_d  = '0;
        unst_d  = '0;
        state_d = S_LOW;
      end
      S_LOW: begin
        if (phase_q == PH_W'(LOW_CYCLES - 1)) begin
          phase_d = '0;
          state_d = S_HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          phase_d = '0;
          ones_d  = ones_q + ONES_W'(sync2_q);
          if (vote_q == ONES_W'(VOTES - 1)) begin
            vote_d  = '0;
            state_d = S_VOTE;
          end else begin
            vote_d  = vote_q + 1'b1;
            state_d = S_LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_VOTE: begin
        data_d[bit_q] = (ones_q > ONES_W'(VOTES / 2));
        if (ones_q != '0 && ones_q != ONES_W'(VOTES)) begin
          unst_d = unst_q + 1'b1;
        end
        ones_d = '0;
        // Challenge only moves here, while the launch line is low.
        chal_d = lfsr_step(chal_q);
        if (bit_q < BIT_W'(RESP_BITS - 1)) begin
          bit_d   = bit_q + 1'b1;
          state_d = S_LOW;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      chal_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      phase_q <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      unst_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q <= state_d;
      seed_q  <= seed_d;
      chal_q  <= chal_d;
      sync1_q <= puf_result;
      sync2_q <= sync1_q;
      phase_q <= phase_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      unst_q  <= unst_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign puf_launch    = (state_q == S_HIGH);
  assign resp_valid    = (state_q == S_DONE);
  assign puf_challenge = chal_q;
  assign resp_data     = data_q;
  assign resp_unstable = unst_q;

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Directed bench for arbiter_puf_engine: tied and voting PUF models, launch timing,
// handshake hold, and asynchronous abort.
module tb_arbiter_puf_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic        busy;
  logic        puf_launch;
  logic [15:0] puf_challenge;
  logic        puf_result;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic [3:0]  resp_unstable;

  int checks = 0;
  int failures = 0;

  // PUF model: 0 tied low, 1 tied high, 2 high on votes 1-3, 3 high on votes 1-2
  int   mode = 1;
  logic pat_q = 1'b0;

  // Launch/challenge monitor state
  logic        mon_clr = 1'b0;
  int          rises = 0, bad_high = 0, low2 = 0, low3 = 0, bad_low = 0, bad_chal = 0;
  int          run_len = 0;
  logic        first_rise = 1'b1;
  logic        prev_launch = 1'b0;
  logic [15:0] prev_chal = '0;

  int          lat;
  logic [15:0] ch1, ch32;
  int          hold_bad;

  arbiter_puf_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .seed          (seed),
    .busy          (busy),
    .puf_launch    (puf_launch),
    .puf_challenge (puf_challenge),
    .puf_result    (puf_result),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_unstable (resp_unstable)
  );

  always #5 clk = ~clk;

  assign puf_result = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : pat_q;

  always @(posedge puf_launch)
    pat_q <= ((rises % 5) < ((mode == 2) ? 3 : 2));

  always @(negedge clk) begin
    if (mon_clr) begin
      rises <= 0; bad_high <= 0; low2 <= 0; low3 <= 0; bad_low <= 0; bad_chal <= 0;
      run_len <= 0; first_rise <= 1'b1;
      prev_launch <= puf_launch; prev_chal <= puf_challenge;
    end else begin
      if (puf_launch && prev_launch && puf_challenge !== prev_chal) bad_chal <= bad_chal + 1;
      if (puf_launch != prev_launch) begin
        if (prev_launch) begin
          if (run_len != 4) bad_high <= bad_high + 1;
        end else begin
          rises <= rises + 1;
          if (!first_rise) begin
            if (run_len == 2)      low2 <= low2 + 1;
            else if (run_len == 3) low3 <= low3 + 1;
            else                   bad_low <= bad_low + 1;
          end
          first_rise <= 1'b0;
        end
        run_len <= 1;
      end else begin
        run_len <= run_len + 1;
      end
      prev_launch <= puf_launch;
      prev_chal   <= puf_challenge;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    mon_clr = 1'b0;
  endtask

  // Pulses start, then counts edges after the sampling edge until resp_valid rises.
  task automatic run_req(input logic [15:0] s, output int l,
                         output logic [15:0] c1, output logic [15:0] c32);
    l = -1; c1 = '0; c32 = '0;
    @(negedge clk);
    seed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 1)  c1  = puf_challenge;
      if (n == 32) c32 = puf_challenge;
      if (resp_valid) begin
        l = n;
        break;
      end
    end
  endtask

  task automatic accept(input string tag, input logic with_start);
    @(negedge clk);
    resp_ready = 1'b1;
    start = with_start;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy",       32'(busy),          32'd0);
    check("rst_launch",     32'(puf_launch),    32'd0);
    check("rst_valid",      32'(resp_valid),    32'd0);
    check("rst_challenge",  32'(puf_challenge), 32'd0);
    check("rst_data",       32'(resp_data),     32'd0);
    check("rst_unstable",   32'(resp_unstable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Tied high, seed 1: full latency, challenge sequence, launch shape
    mode = 1;
    clear_mon();
    run_req(16'h0001, lat, ch1, ch32);
    check("t1_latency",    32'(lat),           32'd249);
    check("t1_chal_first", 32'(ch1),           32'h0001);
    check("t1_chal_next",  32'(ch32),          32'hB400);
    check("t1_data",       32'(resp_data),     32'hFF);
    check("t1_unstable",   32'(resp_unstable), 32'd0);
    check("t1_busy_done",  32'(busy),          32'd1);
    check("t1_rises",      32'(rises),         32'd40);
    check("t1_bad_high",   32'(bad_high),      32'd0);
    check("t1_low2",       32'(low2),          32'd32);
    check("t1_low3",       32'(low3),          32'd7);
    check("t1_bad_low",    32'(bad_low),       32'd0);
    check("t1_chal_moved", 32'(bad_chal),      32'd0);
    accept("t1", 1'b0);

    // Tied low, zero seed replaced by 1
    mode = 0;
    clear_mon();
    run_req(16'h0000, lat, ch1, ch32);
    check("t2_latency",    32'(lat),           32'd249);
    check("t2_chal_first", 32'(ch1),           32'h0001);
    check("t2_data",       32'(resp_data),     32'h00);
    check("t2_unstable",   32'(resp_unstable), 32'd0);
    accept("t2", 1'b0);

    // 3-of-5 majority high
    mode = 2;
    clear_mon();
    run_req(16'hACE1, lat, ch1, ch32);
    check("t3a_latency",  32'(lat),           32'd249);
    check("t3a_data",     32'(resp_data),     32'hFF);
    check("t3a_unstable", 32'(resp_unstable), 32'd8);
    accept("t3a", 1'b0);

    // 2-of-5 majority low
    mode = 3;
    clear_mon();
    run_req(16'h5A5A, lat, ch1, ch32);
    check("t3b_latency",  32'(lat),           32'd249);
    check("t3b_data",     32'(resp_data),     32'h00);
    check("t3b_unstable", 32'(resp_unstable), 32'd8);

    // Hold with ready low, start pulsed in DONE
    hold_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i == 5);
      @(posedge clk);
      #1;
      if (resp_valid !== 1'b1 || busy !== 1'b1 || resp_data !== 8'h00 || resp_unstable !== 4'd8)
        hold_bad++;
    end
    check("hold_stable", 32'(hold_bad), 32'd0);
    accept("hold", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("accept_start_ignored", 32'(busy),          32'd0);
    check("data_after_accept",    32'(resp_data),     32'h00);
    check("unst_after_accept",    32'(resp_unstable), 32'd8);

    // Asynchronous abort mid-request, then a clean rerun
    mode = 1;
    clear_mon();
    @(negedge clk);
    seed = 16'h1234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("abort_pre_data", 32'(resp_data), 32'h07);
    check("abort_pre_busy", 32'(busy),      32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",      32'(busy),          32'd0);
    check("abort_launch",    32'(puf_launch),    32'd0);
    check("abort_valid",     32'(resp_valid),    32'd0);
    check("abort_challenge", 32'(puf_challenge), 32'd0);
    check("abort_data",      32'(resp_data),     32'd0);
    check("abort_unstable",  32'(resp_unstable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    run_req(16'h1234, lat, ch1, ch32);
    check("t4_latency",    32'(lat),       32'd249);
    check("t4_chal_first", 32'(ch1),       32'h1234);
    check("t4_data",       32'(resp_data), 32'hFF);
    check("t4_rises",      32'(rises),     32'd40);
    accept("t4", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter_puf_engine.md
Name: arbiter_puf_engine

Overview:
- Sequencer that drives an external arbiter-PUF delay chain. It is the parametrised successor of the single-shot 8-bit-challenge arbiter PUF.
- From one start request and a seed, it evaluates RESP_BITS challenges generated by an LFSR, each VOTES times, and majority-votes every response bit.
- It returns a RESP_BITS-wide response through a valid/ready handshake, plus a count of unstable bits.
- It sits between the top-level IO wrapper and the combinational mux chain plus arbiter flop.

Parameters:
- C_LENGTH, 16, challenge width = number of mux stages in the delay chain.
- RESP_BITS, 8, response bits produced per request.
- VOTES, 5, evaluations per bit. Must be odd and ≥1; elaboration error otherwise.
- LOW_CYCLES, 2, cycles puf_launch is held low before each launch (≥1).
- SETTLE_CYCLES, 4, cycles puf_launch is held high before sampling (≥3, to cover the 2-flop synchroniser).
- TAPS, 16'hB400, Galois LFSR feedback mask (C_LENGTH bits).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- seed  in  C_LENGTH  initial challenge, captured with start
- busy  out  1  high in every state except IDLE
- puf_launch  out  1  launch edge to both delay-chain inputs
- puf_challenge  out  C_LENGTH  mux select vector
- puf_result  in  1  arbiter output; asynchronous, synchronised internally
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_data  out  RESP_BITS  voted response; bit k belongs to the k-th challenge
- resp_unstable  out  clog2(RESP_BITS+1)  number of bits with a non-unanimous vote

Behaviour:
- Reset: every output is 0, the FSM returns to IDLE, the synchroniser and all counters clear. Reset is asynchronous, so it aborts an operation mid-flight with no partial result.
- puf_result passes through a 2-flop synchroniser. Samples are taken from the second flop.
- FSM states: IDLE, LOAD, LOW, HIGH, VOTE, DONE.
- IDLE: on start=1, go to LOAD and capture seed. A zero seed is replaced by 1.
- LOAD (1 cycle): puf_challenge ← seed. Clear bit index, vote counter, ones counter, resp_data and resp_unstable.
- LOW (LOW_CYCLES cycles): puf_launch=0.
- HIGH (SETTLE_CYCLES cycles): puf_launch=1. On the last HIGH cycle, add the synchronised result to the ones counter.
  - If votes remain, go to LOW.
  - Otherwise go to VOTE.
- VOTE (1 cycle): puf_launch=0.
  - resp_data[bit] ← (ones > VOTES/2).
  - If ones≠0 and ones≠VOTES, resp_unstable increments.
  - Clear ones. Advance the challenge by one Galois step: lsb=c[0]; c=c>>1; if lsb, c^=TAPS.
  - If the bit index is below RESP_BITS-1, increment it and go to LOW. Otherwise go to DONE.
- DONE: resp_valid=1, busy=1. resp_data and resp_unstable are held stable.
  - If resp_valid & resp_ready on an edge, go to IDLE and resp_valid drops the next cycle. The data stays readable until the next LOAD.
- puf_challenge is constant across all votes of one bit. It changes only in LOAD and VOTE, while puf_launch=0.
- Latency: DONE is entered exactly 1 + RESP_BITS·(VOTES·(LOW_CYCLES+SETTLE_CYCLES)+1) edges after the edge that samples start. With the defaults this is 249.
- start asserted in any state other than IDLE is ignored, including DONE and the acceptance cycle itself.
- resp_ready asserted while resp_valid=0 is ignored.
- Counter widths:
  - ones counter: clog2(VOTES+1)
  - bit index: clog2(RESP_BITS)
  - phase counter: clog2(max(LOW_CYCLES,SETTLE_CYCLES)+1)
  - No counter wraps.

Test Plan:
- Defaults, puf_result tied 1, seed 0x0001, start pulse → resp_valid rises 249 cycles after start; resp_data=0xFF, resp_unstable=0. puf_challenge is 0x0001, then 0xB400 after the first VOTE.
- puf_result tied 0, seed 0x0000 → first puf_challenge 0x0001; resp_data=0x00, resp_unstable=0.
- Bench model returns 1 on votes 1–3 and 0 on votes 4–5 of every bit → resp_data=0xFF, resp_unstable=8. Model returns 1 only on votes 1–2 → resp_data=0x00, resp_unstable=8.
- Bench checks puf_launch: 2 low / 4 high cycles per vote, 40 rising edges per request. puf_challenge never changes while puf_launch=1.
- resp_ready held low 20 cycles after resp_valid, with start pulsed meanwhile → data held stable, busy=1, start ignored. Asserting resp_ready for 1 cycle → IDLE, resp_valid=0 the next cycle.
- rst_n asserted low at cycle 100 of a request → all outputs 0 asynchronously. A new start after release completes normally in 249 cycles.
